// File: rtl/mnist_draw_pkg.sv
// Shared constants and types for the MNIST tile renderer: source image geometry,
// address width, 3-bit colour channel and the default fill colour for disabled tiles.
package mnist_draw_pkg;

    localparam int IMG_DIM   = 28;
    localparam int IMG_BYTES = IMG_DIM * IMG_DIM;
    localparam int ADDR_W    = 10;

    typedef logic [2:0] rgb3_t;

    // {r,g,b} fill colour shown when a tile is disabled
    localparam logic [8:0] PLACEHOLDER_DEFAULT = 9'b001_011_001;

endpackage

// File: rtl/mnist_tile_renderer_if.sv
// Image memory bus: one ADDR_W-bit address and one byte of read data per tile, packed
// with tile i at slice i. The renderer is master, the image memories are slave.
interface mnist_tile_renderer_if
    import mnist_draw_pkg::*;
#(
    parameter int NUM_TILES = 3
);

    logic [NUM_TILES*ADDR_W-1:0] image_address;
    logic [NUM_TILES*8-1:0]      image_data;

    modport master (output image_address, input  image_data);
    modport slave  (input  image_address, output image_data);

endinterface

// File: rtl/mnist_tile_addr_gen.sv
// One tile: X/Y window compare on the lookahead column and byte address arithmetic.
// Purely combinational; the renderer registers the address and arbitrates overlaps.
module mnist_tile_addr_gen
    import mnist_draw_pkg::*;
#(
    parameter int TILE_IDX      = 0,
    parameter int IMG_DIM       = mnist_draw_pkg::IMG_DIM,
    parameter int SCALE_X_SHIFT = 2,
    parameter int SCALE_Y_SHIFT = 1,
    parameter int TILE_PITCH_Y  = 108
) (
    input  logic [19:0]       xl_i,
    input  logic [19:0]       y_i,
    input  logic [19:0]       base_x_i,
    input  logic [19:0]       base_y_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int W_X = IMG_DIM << SCALE_X_SHIFT;
    localparam int W_Y = IMG_DIM << SCALE_Y_SHIFT;

    // One extra bit so window edges near 2^20 do not wrap back into range.
    logic [20:0] top;
    logic [20:0] dy;
    logic [19:0] dx;
    logic        in_x;
    logic        in_y;

    always_comb begin
        top    = {1'b0, base_y_i} + 21'(TILE_IDX * TILE_PITCH_Y);
        in_x   = ({1'b0, xl_i} >= {1'b0, base_x_i}) &&
                 ({1'b0, xl_i} <  {1'b0, base_x_i} + 21'(W_X));
        in_y   = ({1'b0, y_i} >= top) && ({1'b0, y_i} < top + 21'(W_Y));
        dx     = xl_i - base_x_i;
        dy     = {1'b0, y_i} - top;
        hit_o  = in_x && in_y;
        addr_o = ADDR_W'(32'(dy >> SCALE_Y_SHIFT) * IMG_DIM + 32'(dx >> SCALE_X_SHIFT));
    end

endmodule

// File: rtl/mnist_tile_renderer.sv
// Draws NUM_TILES stacked, magnified 28x28 byte images into the VGA stream; output is
// RD_LATENCY+1 edges behind the lookahead, no backpressure. Tint: `MNIST_TILE_TINT_EN.
module mnist_tile_renderer
    import mnist_draw_pkg::*;
#(
    parameter int         NUM_TILES       = 3,
    parameter int         IMG_DIM         = mnist_draw_pkg::IMG_DIM,
    parameter int         SCALE_X_SHIFT   = 2,
    parameter int         SCALE_Y_SHIFT   = 1,
    parameter int         TILE_PITCH_Y    = 108,
    parameter int         H_ORIGIN        = 320,
    parameter int         V_ORIGIN        = 45,
    parameter int         RD_LATENCY      = 1,
    parameter logic [8:0] PLACEHOLDER_RGB = PLACEHOLDER_DEFAULT
) (
    input  logic                   CLOCK_50,
    input  logic                   RST_N,
    input  logic [19:0]            dot,
    input  logic [19:0]            y_count_in,
    input  logic [19:0]            OFFSET_BASE_X,
    input  logic [19:0]            OFFSET_BASE_Y,
    input  logic [NUM_TILES-1:0]   tile_enable,
`ifdef MNIST_TILE_TINT_EN
    input  logic [NUM_TILES*9-1:0] tile_tint,
`endif
    mnist_tile_renderer_if.master  mem,
    output rgb3_t                  r_val,
    output rgb3_t                  g_val,
    output rgb3_t                  b_val,
    output logic                   flagOK
);

    localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    logic [19:0]       xl;
    logic [19:0]       y;
    logic [NUM_TILES-1:0] gen_hit;
    logic [ADDR_W-1:0] gen_addr  [NUM_TILES];
    rgb3_t             tile_gray [NUM_TILES];
`ifdef MNIST_TILE_TINT_EN
    logic [8:0]        tint_a    [NUM_TILES];
`endif

    logic              look_hit_d;
    logic [IDX_W-1:0]  look_idx_d;
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [IDX_W-1:0]  pipe_idx_q [RD_LATENCY];
    logic [ADDR_W-1:0] addr_q    [NUM_TILES];

    logic              tap_vld;
    logic [IDX_W-1:0]  tap_idx;
    logic              flag_d;
    logic              flag_q;
    logic [8:0]        rgb_d;
    rgb3_t             r_q;
    rgb3_t             g_q;
    rgb3_t             b_q;

    // Lookahead column: the address issued now is consumed RD_LATENCY edges later.
    assign xl = dot - 20'(H_ORIGIN) + 20'(RD_LATENCY);
    assign y  = y_count_in - 20'(V_ORIGIN);

    for (genvar i = 0; i < NUM_TILES; i++) begin : g_tile
        mnist_tile_addr_gen #(
            .TILE_IDX     (i),
            .IMG_DIM      (IMG_DIM),
            .SCALE_X_SHIFT(SCALE_X_SHIFT),
            .SCALE_Y_SHIFT(SCALE_Y_SHIFT),
            .TILE_PITCH_Y (TILE_PITCH_Y)
        ) u_addr_gen (
            .xl_i    (xl),
            .y_i     (y),
            .base_x_i(OFFSET_BASE_X),
            .base_y_i(OFFSET_BASE_Y),
            .hit_o   (gen_hit[i]),
            .addr_o  (gen_addr[i])
        );

        assign mem.image_address[ADDR_W*i +: ADDR_W] = addr_q[i];
        assign tile_gray[i] = mem.image_data[8*i+5 +: 3];
`ifdef MNIST_TILE_TINT_EN
        assign tint_a[i] = tile_tint[9*i +: 9];
`endif
    end

    // Descending scan so the lowest matching tile index is the one that sticks.
    always_comb begin
        look_hit_d = 1'b0;
        look_idx_d = '0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (gen_hit[i]) begin
                look_hit_d = 1'b1;
                look_idx_d = IDX_W'(i);
            end
        end
    end

    assign tap_vld = pipe_vld_q[RD_LATENCY-1];
    assign tap_idx = pipe_idx_q[RD_LATENCY-1];

    always_comb begin
        flag_d = tap_vld;
        rgb_d  = {r_q, g_q, b_q};
        if (tap_vld) begin
            if (tile_enable[tap_idx]) begin
`ifdef MNIST_TILE_TINT_EN
                rgb_d = {tile_gray[tap_idx] & tint_a[tap_idx][8:6],
                         tile_gray[tap_idx] & tint_a[tap_idx][5:3],
                         tile_gray[tap_idx] & tint_a[tap_idx][2:0]};
`else
                rgb_d = {tile_gray[tap_idx], tile_gray[tap_idx], tile_gray[tap_idx]};
`endif
            end else begin
                rgb_d = PLACEHOLDER_RGB;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            pipe_vld_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) pipe_idx_q[s] <= '0;
            for (int i = 0; i < NUM_TILES; i++) addr_q[i] <= '0;
            flag_q <= 1'b0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            pipe_vld_q[0] <= look_hit_d;
            pipe_idx_q[0] <= look_idx_d;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
            for (int i = 0; i < NUM_TILES; i++) begin
                if (look_hit_d && look_idx_d == IDX_W'(i)) addr_q[i] <= gen_addr[i];
            end
            flag_q            <= flag_d;
            {r_q, g_q, b_q}   <= rgb_d;
        end
    end

    assign r_val  = r_q;
    assign g_val  = g_q;
    assign b_val  = b_q;
    assign flagOK = flag_q;

endmodule

// File: tb/tb_mnist_tile_renderer.sv
// Random line sweeps against a coordinate-level reference, for read latencies 1 and 3.
module tb_mnist_tile_renderer;
    import mnist_draw_pkg::*;

    localparam int NT = 3;
    localparam int TW = NT * 9;
    localparam int M  = 32'hFFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [19:0]   dot = '0, y_count_in = '0, OFFSET_BASE_X = '0, OFFSET_BASE_Y = '0;
    logic [NT-1:0] tile_enable = '1;
`ifdef MNIST_TILE_TINT_EN
    logic [TW-1:0] tile_tint = '1;
`endif
    rgb3_t r1, g1, b1, r3, g3, b3;
    logic  flag1, flag3;

    mnist_tile_renderer_if #(.NUM_TILES(NT)) mif1();
    mnist_tile_renderer_if #(.NUM_TILES(NT)) mif3();

    mnist_tile_renderer #(.NUM_TILES(NT), .RD_LATENCY(1)) u_dut1 (
        .CLOCK_50(clk), .RST_N(rst_n), .dot(dot), .y_count_in(y_count_in),
        .OFFSET_BASE_X(OFFSET_BASE_X), .OFFSET_BASE_Y(OFFSET_BASE_Y),
        .tile_enable(tile_enable),
`ifdef MNIST_TILE_TINT_EN
        .tile_tint(tile_tint),
`endif
        .mem(mif1), .r_val(r1), .g_val(g1), .b_val(b1), .flagOK(flag1));

    mnist_tile_renderer #(.NUM_TILES(NT), .RD_LATENCY(3)) u_dut3 (
        .CLOCK_50(clk), .RST_N(rst_n), .dot(dot), .y_count_in(y_count_in),
        .OFFSET_BASE_X(OFFSET_BASE_X), .OFFSET_BASE_Y(OFFSET_BASE_Y),
        .tile_enable(tile_enable),
`ifdef MNIST_TILE_TINT_EN
        .tile_tint(tile_tint),
`endif
        .mem(mif3), .r_val(r3), .g_val(g3), .b_val(b3), .flagOK(flag3));

    always #10 clk = ~clk;

    // Image memories: latency 1 reads combinationally, latency 3 adds two address registers.
    logic [7:0]        mem [NT][IMG_BYTES];
    logic [ADDR_W-1:0] a1 [NT];
    logic [ADDR_W-1:0] a2 [NT];

    always @(posedge clk) begin
        for (int t = 0; t < NT; t++) begin
            a1[t] <= mif3.image_address[ADDR_W*t +: ADDR_W];
            a2[t] <= a1[t];
        end
    end

    always_comb begin
        mif1.image_data = '0;
        mif3.image_data = '0;
        for (int t = 0; t < NT; t++) begin
            mif1.image_data[8*t +: 8] = mem[t][mif1.image_address[ADDR_W*t +: ADDR_W]];
            mif3.image_data[8*t +: 8] = mem[t][a2[t]];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int exp_addr [2][NT];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (dot %0d y_count_in %0d)",
                      tag, got, exp, dot, y_count_in);
    endtask

    // Which tile owns visible pixel (x,y), and the source byte it shows; -1 if none.
    function automatic int locate(input int x, input int y, input int bx, input int by,
                                  output int addr);
        addr = 0;
        if (x < bx || x >= bx + IMG_DIM * 4) return -1;
        for (int i = 0; i < NT; i++) begin
            int top = by + i * 108;
            if (y >= top && y < top + IMG_DIM * 2) begin
                addr = ((y - top) / 2) * IMG_DIM + (x - bx) / 4;
                return i;
            end
        end
        return -1;
    endfunction

    task automatic check_pixel(input int li, input int d, input int yc, input int bx,
                               input int by, input int k, input bit after_rst);
        int    lat = (li != 0) ? 3 : 1;
        string tag = (li != 0) ? "L3" : "L1";
        int    x = (d - 320) & M;
        int    y = (yc - 45) & M;
        int    a;
        int    t;
        logic [NT*ADDR_W-1:0] got_addr = (li != 0) ? mif3.image_address : mif1.image_address;
        logic  got_flag = (li != 0) ? flag3 : flag1;
        rgb3_t got_r = (li != 0) ? r3 : r1;
        rgb3_t got_g = (li != 0) ? g3 : g1;
        rgb3_t got_b = (li != 0) ? b3 : b1;
        logic [7:0] byte_v;
        logic [8:0] ph = 9'b001_011_001;
        logic [8:0] ergb;

        t = locate((x + lat) & M, y, bx, by, a);
        if (t >= 0) exp_addr[li][t] = a;
        for (int i = 0; i < NT; i++)
            check_eq({tag, " image_address"}, int'(got_addr[ADDR_W*i +: ADDR_W]), exp_addr[li][i]);

        if (k >= lat) begin
            t = locate(x, y, bx, by, a);
            check_eq({tag, " flagOK"}, int'(got_flag), (t >= 0) ? 1 : 0);
            if (t >= 0) begin
                byte_v = mem[t][a];
                if (tile_enable[t]) begin
                    ergb = {byte_v[7:5], byte_v[7:5], byte_v[7:5]};
`ifdef MNIST_TILE_TINT_EN
                    ergb = ergb & tile_tint[9*t +: 9];
`endif
                end else begin
                    ergb = ph;
                end
                check_eq({tag, " r_val"}, int'(got_r), int'(ergb[8:6]));
                check_eq({tag, " g_val"}, int'(got_g), int'(ergb[5:3]));
                check_eq({tag, " b_val"}, int'(got_b), int'(ergb[2:0]));
            end
        end else if (after_rst) begin
            check_eq({tag, " flagOK after reset"}, int'(got_flag), 0);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst flagOK L1", int'(flag1), 0);
        check_eq("rst flagOK L3", int'(flag3), 0);
        check_eq("rst rgb L1", int'({r1, g1, b1}), 0);
        check_eq("rst rgb L3", int'({r3, g3, b3}), 0);
        check_eq("rst address L1", int'(mif1.image_address), 0);
        check_eq("rst address L3", int'(mif3.image_address), 0);
        for (int li = 0; li < 2; li++)
            for (int i = 0; i < NT; i++) exp_addr[li][i] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_line(input int yc, input int bx, input int by, input bit rand_en,
                            input logic [NT-1:0] en, input int rst_at);
        int k = 0;
        bit after_rst = 1'b0;
        int de = 320 + bx + IMG_DIM * 4 + 8;
        y_count_in    = 20'(yc);
        OFFSET_BASE_X = 20'(bx);
        OFFSET_BASE_Y = 20'(by);
`ifdef MNIST_TILE_TINT_EN
        tile_tint = TW'($urandom);
`endif
        for (int d = 310; d <= de; d++) begin
            if (d == rst_at) begin
                do_reset();
                k = 0;
                after_rst = 1'b1;
            end
            dot = 20'(d);
            tile_enable = rand_en ? NT'($urandom) : en;
            @(posedge clk);
            #1;
            check_pixel(0, d, yc, bx, by, k, after_rst);
            check_pixel(1, d, yc, bx, by, k, after_rst);
            k++;
        end
    endtask

    initial begin
        for (int t = 0; t < NT; t++)
            for (int a = 0; a < IMG_BYTES; a++) mem[t][a] = 8'($urandom);
        mem[0][0] = 8'hE0;
        mem[0][1] = 8'h1F;
        for (int li = 0; li < 2; li++)
            for (int i = 0; i < NT; i++) exp_addr[li][i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset flagOK L1", int'(flag1), 0);
        check_eq("reset flagOK L3", int'(flag3), 0);
        check_eq("reset rgb L1", int'({r1, g1, b1}), 0);
        check_eq("reset address L3", int'(mif3.image_address), 0);
        rst_n = 1'b1;

        // Tile 0 rows 0, 1, 27 and the first line below it; tile 1 row 0; tile 2 disabled.
        run_line(45,             0, 0, 1'b0, 3'b111, -1);
        run_line(47,             0, 0, 1'b0, 3'b111, -1);
        run_line(45 + 55,        0, 0, 1'b0, 3'b111, -1);
        run_line(45 + 56,        0, 0, 1'b0, 3'b111, -1);
        run_line(45 + 108,       0, 0, 1'b0, 3'b111, -1);
        run_line(45 + 216 + 3,   0, 0, 1'b0, 3'b011, -1);
        run_line(45 + 108 + 10,  0, 0, 1'b0, 3'b111, 380);
        run_line(45 + 108 + 10,  7, 3, 1'b1, 3'b111, 360);

        for (int n = 0; n < 40; n++) begin
            int by = $urandom_range(0, 20);
            int bx = $urandom_range(0, 40);
            run_line($urandom_range(30, 45 + by + 3 * 108 + 4), bx, by,
                     1'($urandom), NT'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
